frame_share_dbuf: RTL

- Double-buffered shared memory between a host Beta (physics) and a client Beta (laser), successor to the single-bank shared memory.
- Host writes a complete display list into the back bank while the client reads the front bank. A swap handshake exchanges the banks so the client never sees a torn frame.
- Parametrised in width, depth and swap mode, with interrupt outputs and status/control registers.
- Sits beside each Beta's address decode; write enables arrive already qualified by the decoder's select.

---
 rtl/frame_share_dbuf_pkg.sv | 38 +++
 rtl/frame_share_dbuf_bank_ram.sv | 27 ++
 rtl/frame_share_dbuf.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/frame_share_dbuf_pkg.sv
// Shared constants, FSM state type and status packing for the double-buffered
// host/client frame memory.
package frame_share_dbuf_pkg;

    localparam int unsigned REG_CTRL  = 0;

    localparam int unsigned CTRL_SWAP = 0;
    localparam int unsigned CTRL_OVR  = 2;
    localparam int unsigned CTRL_ACK  = 0;

    localparam int unsigned STAT_NEW  = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned FCNT_LSB  = 8;

    localparam int unsigned HSTAT_PEND  = 0;
    localparam int unsigned HSTAT_FRONT = 1;
    localparam int unsigned HSTAT_OVR   = 2;

    localparam int unsigned FCNT_W   = 16;
    localparam int unsigned STATUS_W = FCNT_LSB + FCNT_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2
    } dbuf_state_t;

    // Status word layout shared by both sides: frame count above three flag bits.
    function automatic logic [STATUS_W-1:0] pack_status(input logic [FCNT_W-1:0] fcnt,
                                                        input logic [2:0]        flags);
        logic [STATUS_W-1:0] s;
        s = '0;
        s[FCNT_LSB +: FCNT_W] = fcnt;
        s[2:0] = flags;
        return s;
    endfunction

endpackage

// File: rtl/frame_share_dbuf_bank_ram.sv
// One bank of the frame memory: simple dual-port synchronous RAM, read-first.
module dbuf_bank_ram
    import frame_share_dbuf_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/frame_share_dbuf.sv
// Double-buffered shared memory: host fills the back bank, client reads the
// front bank, and a swap handshake exchanges them between complete frames.
module frame_share_dbuf
    import frame_share_dbuf_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned SWAP_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       host_addr,
    input  logic [DATA_W-1:0] host_din,
    input  logic              host_mwe,
    output logic [DATA_W-1:0] host_dout,
    input  logic [31:0]       client_addr,
    input  logic [DATA_W-1:0] client_din,
    input  logic              client_mwe,
    output logic [DATA_W-1:0] client_dout,
    output logic              irq_host,
    output logic              irq_client,
    output logic              front_sel
);

    localparam int unsigned SEL_BIT = ADDR_W + 2;

    logic [ADDR_W-1:0] host_word;
    logic [ADDR_W-1:0] client_word;
    logic              host_reg;
    logic              client_reg;
    logic              host_reg0;
    logic              client_reg0;

    logic              host_data_we;
    logic              swap_req;
    logic              ovr_clear;
    logic              client_ack;
    logic              client_rd;

    dbuf_state_t       state_q;
    dbuf_state_t       state_d;
    logic              front_q;
    logic              overrun_q;
    logic              client_done_q;
    logic              new_frame_q;
    logic [FCNT_W-1:0] frame_cnt_q;

    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;

    logic [DATA_W-1:0] host_stat;
    logic [DATA_W-1:0] client_stat;
    logic              rd_front_q;
    logic              host_is_reg_q;
    logic              client_is_reg_q;
    logic [DATA_W-1:0] host_reg_q;
    logic [DATA_W-1:0] client_reg_q;

    assign host_word   = host_addr[ADDR_W+1:2];
    assign client_word = client_addr[ADDR_W+1:2];
    assign host_reg    = host_addr[SEL_BIT];
    assign client_reg  = client_addr[SEL_BIT];
    assign host_reg0   = host_reg && (host_word == ADDR_W'(REG_CTRL));
    assign client_reg0 = client_reg && (client_word == ADDR_W'(REG_CTRL));

    assign host_data_we = host_mwe && !host_reg;
    assign swap_req     = host_mwe && host_reg0 && host_din[CTRL_SWAP];
    assign ovr_clear    = host_mwe && host_reg0 && host_din[CTRL_OVR];
    assign client_ack   = client_mwe && client_reg0 && client_din[CTRL_ACK];
    assign client_rd    = !client_mwe && client_reg0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (swap_req) state_d = PENDING;
            PENDING: if ((SWAP_MODE != 0) || client_done_q) state_d = SWAP;
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The SWAP cycle overrides a coincident client ack or status read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            front_q       <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_q     <= 1'b0;
            client_done_q <= 1'b1;
            new_frame_q   <= 1'b0;
            irq_host      <= 1'b0;
            irq_client    <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_host   <= (state_d == SWAP);
            irq_client <= (state_d == SWAP);
            if (host_data_we && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (ovr_clear) begin
                overrun_q <= 1'b0;
            end
            if (state_q == SWAP) begin
                front_q       <= ~front_q;
                frame_cnt_q   <= frame_cnt_q + FCNT_W'(1);
                client_done_q <= 1'b0;
                new_frame_q   <= 1'b1;
            end else begin
                if (client_ack) client_done_q <= 1'b1;
                if (client_rd)  new_frame_q   <= 1'b0;
            end
        end
    end

    // Host owns the bank that is not in front; writes only land while IDLE.
    assign we0      = host_data_we && (state_q == IDLE) && front_q;
    assign we1      = host_data_we && (state_q == IDLE) && !front_q;
    assign rd_addr0 = front_q ? host_word : client_word;
    assign rd_addr1 = front_q ? client_word : host_word;

    dbuf_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk     (clk),
        .we      (we0),
        .wr_addr (host_word),
        .wr_data (host_din),
        .rd_addr (rd_addr0),
        .rd_data (q0)
    );

    dbuf_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk     (clk),
        .we      (we1),
        .wr_addr (host_word),
        .wr_data (host_din),
        .rd_addr (rd_addr1),
        .rd_data (q1)
    );

    always_comb begin
        host_stat   = '0;
        client_stat = '0;
        host_stat[STATUS_W-1:0]   = pack_status(frame_cnt_q,
                                                {overrun_q, front_q, state_q != IDLE});
        client_stat[STATUS_W-1:0] = pack_status(frame_cnt_q,
                                                {1'b0, client_done_q, new_frame_q});
    end

    // Output selects are registered alongside the RAM read, so the bank mapping
    // used for data is the one in force when the address was presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_front_q      <= 1'b0;
            host_is_reg_q   <= 1'b1;
            client_is_reg_q <= 1'b1;
            host_reg_q      <= '0;
            client_reg_q    <= '0;
        end else begin
            rd_front_q      <= front_q;
            host_is_reg_q   <= host_reg;
            client_is_reg_q <= client_reg;
            host_reg_q      <= host_reg0 ? host_stat : '0;
            client_reg_q    <= client_reg0 ? client_stat : '0;
        end
    end

    assign host_dout   = host_is_reg_q ? host_reg_q : (rd_front_q ? q0 : q1);
    assign client_dout = client_is_reg_q ? client_reg_q : (rd_front_q ? q1 : q0);
    assign front_sel   = front_q;

    logic unused_inputs;
    assign unused_inputs = ^{host_addr[31:SEL_BIT+1], host_addr[1:0],
                             client_addr[31:SEL_BIT+1], client_addr[1:0],
                             client_din[DATA_W-1:1]};

endmodule
